// File: rtl/mic_frame_sequencer.sv
// Mic frame sequencer: decimates the ADC word, packs it as a complex sample
// and streams fixed-length frames with first/last markers through a FIFO.
module mic_frame_sequencer #(
  parameter int WIDTH      = 32,
  parameter int SHIFT      = 7,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             adc_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      decim,
  input  logic [11:0]      mic_sample,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  localparam int HW = WIDTH / 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int EW = HW + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH
  } state_t;

  state_t        state;
  logic [15:0]   decim_lat;
  logic [15:0]   div_cnt;
  logic [IW-1:0] idx;
  logic          stop_pend;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;

  logic [HW-1:0] sample_real;
  logic [EW-1:0] head;
  logic          tick;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          idx_last;

  always_comb begin
    sample_real       = '0;
    sample_real[11:0] = mic_sample >> SHIFT;
  end

  assign tick     = (div_cnt == decim_lat);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign pop      = out_valid & out_ready;
  assign push_req = (state == ST_CAPTURE) & tick;
  assign push     = push_req & (~full | pop);
  assign idx_last = (idx == IW'(FRAME_LEN - 1));

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ?
                     {{(WIDTH-HW){1'b0}}, head[HW-1:0]} : '0;
  assign out_first = out_valid & head[HW+1];
  assign out_last  = out_valid & head[HW];
  assign busy      = (state != ST_IDLE);

  always_comb begin
    count_nxt = count;
    if (push & ~pop)
      count_nxt = count + 1'b1;
    else if (pop & ~push)
      count_nxt = count - 1'b1;
  end

  // Storage needs no reset: contents are only visible while count != 0.
  always_ff @(posedge adc_clk) begin
    if (push)
      mem[wr_ptr] <= {(idx == '0), idx_last, sample_real};
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      decim_lat <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      stop_pend <= 1'b0;
      overrun   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CAPTURE;
            decim_lat <= decim;
            div_cnt   <= '0;
            idx       <= '0;
            overrun   <= 1'b0;
            stop_pend <= stop;
          end
        end
        ST_CAPTURE: begin
          if (stop)
            stop_pend <= 1'b1;
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (push_req & ~push)
            overrun <= 1'b1;
          // A dropped sample keeps idx so frames stay index-contiguous.
          if (push) begin
            idx <= idx_last ? '0 : idx + 1'b1;
            if (idx_last & stop_pend)
              state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (count == '0)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
